seg_display_controller: RTL and testbench



---
 rtl/seg_chars_pkg.sv | 28 ++
 rtl/seg_char_decoder.sv | 33 +++
 rtl/seg_display_controller.sv | 124 ++++++++++++
 tb/tb_seg_display_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_chars_pkg.sv
// Shared character codes, character type and scan-state encoding for the
// seven-segment display path and the mode modules that feed it.
package seg_chars_pkg;

    typedef logic [4:0] char_t;

    localparam char_t C_BLANK  = 5'd31;
    localparam char_t C_HYPHEN = 5'd10;
    localparam char_t C_E      = 5'd11;
    localparam char_t C_r      = 5'd12;
    localparam char_t C_g      = 5'd9;
    localparam char_t C_o      = 5'd17;
    localparam char_t C_S      = 5'd5;
    localparam char_t C_b      = 5'd18;
    localparam char_t C_d      = 5'd19;
    localparam char_t C_1      = 5'd1;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_char_decoder.sv
// Character code to active-low {g,f,e,d,c,b,a} cathode pattern.
// Unknown codes render as blank.
module seg_char_decoder
    import seg_chars_pkg::*;
(
    input  char_t      code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'd0:     seg = 7'h40;
            5'd1:     seg = 7'h79;
            5'd2:     seg = 7'h24;
            5'd3:     seg = 7'h30;
            5'd4:     seg = 7'h19;
            5'd5:     seg = 7'h12;
            5'd6:     seg = 7'h02;
            5'd7:     seg = 7'h78;
            5'd8:     seg = 7'h00;
            5'd9:     seg = 7'h10;
            C_HYPHEN: seg = 7'h3F;
            C_E:      seg = 7'h06;
            C_r:      seg = 7'h2F;
            C_o:      seg = 7'h23;
            C_b:      seg = 7'h03;
            C_d:      seg = 7'h21;
            default:  seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_display_controller.sv
// Four-digit common-anode multiplexer: latches a whole frame at slot 0,
// scans digits with anode dead-time at the start of every slot.
module seg_display_controller
    import seg_chars_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [19:0] seg_data,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_LAST  = PW'(DEAD_CYCLES - 1);

    logic [PW-1:0] presc_reg;
    logic [1:0]    index_reg;
    scan_state_t   state_reg;
    char_t         frame_chars_reg [NUM_DIGITS];
    logic [3:0]    dp_frame_reg;

    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic          frame_tick_reg;

    char_t         in_chars [NUM_DIGITS];
    char_t         cur_char;
    logic [6:0]    cur_seg;
    logic          presc_wrap;
    logic          latch_now;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign in_chars[gi] = seg_data[gi*5 +: 5];
        end
    endgenerate

    assign presc_wrap = (presc_reg == PRESC_LAST);
    assign latch_now  = (presc_reg == '0) && (index_reg == 2'd0);

    // Scan timing and dead/drive FSM share one register block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
            index_reg <= 2'd0;
            state_reg <= ST_DEAD;
        end else begin
            if (presc_wrap) begin
                presc_reg <= '0;
                index_reg <= index_reg + 2'd1;
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
            case (state_reg)
                ST_DEAD:  if (presc_reg == DEAD_LAST) state_reg <= ST_DRIVE;
                ST_DRIVE: if (presc_wrap)             state_reg <= ST_DEAD;
                default:  state_reg <= ST_DEAD;
            endcase
        end
    end

    // Whole-frame capture so a digit never shows a half-updated frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                frame_chars_reg[i] <= C_BLANK;
            end
            dp_frame_reg <= 4'b0000;
        end else if (latch_now) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                frame_chars_reg[i] <= in_chars[i];
            end
            dp_frame_reg <= dp_in;
        end
    end

    assign cur_char = frame_chars_reg[index_reg];

    seg_char_decoder u_decoder (
        .code (cur_char),
        .seg  (cur_seg)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (state_reg == ST_DRIVE && enable) begin
            an_next  = ~(4'b0001 << index_reg);
            seg_next = cur_seg;
            dp_next  = ~dp_frame_reg[index_reg];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_reg         <= AN_OFF;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            frame_tick_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_tick_reg <= latch_now;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg_display_controller.sv
// Directed bench with a cycle-count reference model feeding an expected-value
// queue; each negedge pops one entry and checks the pins against it.
module tb_seg_display_controller;

    localparam int RD = 8;
    localparam int DC = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [19:0] seg_data;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t exp_q [$];

    int         m_cnt = 0;
    logic [4:0] m_frame [4];
    logic [3:0] m_dpf;

    seg_display_controller #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .seg_data   (seg_data),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_decode(input logic [4:0] c);
        case (c)
            5'd0:  return 7'h40;
            5'd1:  return 7'h79;
            5'd2:  return 7'h24;
            5'd3:  return 7'h30;
            5'd4:  return 7'h19;
            5'd5:  return 7'h12;
            5'd6:  return 7'h02;
            5'd7:  return 7'h78;
            5'd8:  return 7'h00;
            5'd9:  return 7'h10;
            5'd10: return 7'h3F;
            5'd11: return 7'h06;
            5'd12: return 7'h2F;
            5'd17: return 7'h23;
            5'd18: return 7'h03;
            5'd19: return 7'h21;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference: cycles since reset release determine slot and phase.
    always @(posedge clk) begin
        exp_t e;
        int p, idx, ph;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
        if (!reset_n) begin
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_frame[i] = 5'd31;
            m_dpf = 4'b0000;
        end else begin
            p   = m_cnt % RD;
            idx = (m_cnt / RD) % 4;
            ph  = m_cnt % FRAME;
            if (ph == 0) begin
                for (int i = 0; i < 4; i++) m_frame[i] = seg_data[i*5 +: 5];
                m_dpf = dp_in;
            end
            e.tick = (ph == 0);
            if (p >= DC && enable) begin
                e.an  = ~(4'b0001 << idx);
                e.seg = ref_decode(m_frame[idx]);
                e.dp  = ~m_dpf[idx];
            end
            m_cnt = m_cnt + 1;
        end
        exp_q.push_back(e);
    end

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL queue_empty cycle=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                assert (an === e.an) else begin
                    failures++;
                    $error("FAIL an cycle=%0d got=%b exp=%b", cyc, an, e.an);
                end
                checks++;
                assert (seg === e.seg) else begin
                    failures++;
                    $error("FAIL seg cycle=%0d got=%h exp=%h", cyc, seg, e.seg);
                end
                checks++;
                assert (dp === e.dp) else begin
                    failures++;
                    $error("FAIL dp cycle=%0d got=%b exp=%b", cyc, dp, e.dp);
                end
                checks++;
                assert (frame_tick === e.tick) else begin
                    failures++;
                    $error("FAIL frame_tick cycle=%0d got=%b exp=%b", cyc, frame_tick, e.tick);
                end
            end
        end
    endtask

    // Advance until the next model cycle sits at the given frame phase.
    task automatic step_to(input int phase);
        for (int k = 0; k < 2 * FRAME; k++) begin
            if ((m_cnt % FRAME) == phase) break;
            step(1);
        end
    endtask

    task automatic load(input logic [4:0] d3, input logic [4:0] d2,
                        input logic [4:0] d1, input logic [4:0] d0);
        seg_data = {d3, d2, d1, d0};
        $display("drive seg_data=%0d,%0d,%0d,%0d dp_in=%b enable=%b", d3, d2, d1, d0, dp_in, enable);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b1;
        dp_in    = 4'b0000;
        seg_data = 20'($urandom);
        step(3);

        load(5'd0, 5'd1, 5'd2, 5'd3);
        reset_n = 1'b1;
        step(2 * FRAME);

        load(5'd10, 5'd11, 5'd12, 5'd12);
        step(2 * FRAME);
        load(5'd18, 5'd17, 5'd5, 5'd31);
        step(2 * FRAME);

        load(5'd1, 5'd1, 5'd1, 5'd1);
        step(FRAME);
        step_to(RD + 3);
        load(5'd2, 5'd2, 5'd2, 5'd2);
        step(2 * FRAME);

        dp_in = 4'b0100;
        load(5'd8, 5'd9, 5'd4, 5'd6);
        step(2 * FRAME);

        step_to(2 * RD + 4);
        enable = 1'b0;
        $display("drive enable=0");
        step(FRAME + 5);
        enable = 1'b1;
        $display("drive enable=1");
        step(FRAME);

        step_to(RD + 5);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        assert (an === 4'hF) else begin
            failures++;
            $error("FAIL async_an got=%b exp=1111", an);
        end
        checks++;
        assert (seg === 7'h7F) else begin
            failures++;
            $error("FAIL async_seg got=%h exp=7f", seg);
        end
        checks++;
        assert (dp === 1'b1) else begin
            failures++;
            $error("FAIL async_dp got=%b exp=1", dp);
        end
        checks++;
        assert (frame_tick === 1'b0) else begin
            failures++;
            $error("FAIL async_tick got=%b exp=0", frame_tick);
        end
        $display("async reset mid-slot an=%b seg=%h dp=%b", an, seg, dp);
        step(2);
        load(5'd7, 5'd6, 5'd5, 5'd4);
        reset_n = 1'b1;
        step(FRAME + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
